alu: RTL and testbench



---
 rtl/alu.sv | 115 +++++++++++
 tb/tb_alu.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu.sv
// Registered 8-bit ALU: add/sub/inc/dec/and/or/xor/not with carry, overflow, negative and zero flags.
// Latency: 1 cycle; inputs sampled on a rising edge appear on the outputs right after it.
// Backpressure: none; a new operation is accepted on every cycle.
//
// Ports:
//   clk        system clock, outputs update on the rising edge
//   rst_n      asynchronous active-low reset, clears every output (Zero included)
//   A, B       8-bit operands (B unused by INC, DEC, NOT)
//   X, Y, Z    operation select, {X,Y,Z} with X as the MSB
//   C          registered 8-bit result
//   cout       registered carry (ADD/INC) or borrow (SUB/DEC), 0 for logic ops
//   Ov         registered signed overflow, 0 for logic ops
//   Neg        registered C[7]
//   Zero       registered (C == 0); forced to 0 while in reset
module alu (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] A,
    input  logic [7:0] B,
    input  logic       X,
    input  logic       Y,
    input  logic       Z,
    output logic [7:0] C,
    output logic       cout,
    output logic       Ov,
    output logic       Neg,
    output logic       Zero
);

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_INC = 3'b010,
        OP_DEC = 3'b011,
        OP_AND = 3'b100,
        OP_OR  = 3'b101,
        OP_XOR = 3'b110,
        OP_NOT = 3'b111
    } op_e;

    op_e        op;
    logic [7:0] arith_b;    // second arithmetic operand: B or the constant 1
    logic [8:0] sum9;       // 9-bit sum/difference; bit 8 is carry or borrow
    logic       is_sub;

    logic [7:0] c_d,    c_q;
    logic       cout_d, cout_q;
    logic       ov_d,   ov_q;
    logic       neg_d,  neg_q;
    logic       zero_d, zero_q;

    assign op = op_e'({X, Y, Z});

    always_comb begin
        // INC/DEC share the ADD/SUB path with the operand replaced by 1;
        // Z picks subtract across the whole arithmetic half of the op space.
        arith_b = Y ? 8'h01 : B;
        is_sub  = Z;
        if (is_sub) begin
            // Unsigned 9-bit subtract: bit 8 ends up set exactly when A < arith_b.
            sum9 = {1'b0, A} - {1'b0, arith_b};
        end else begin
            sum9 = {1'b0, A} + {1'b0, arith_b};
        end
    end

    always_comb begin
        c_d    = 8'h00;
        cout_d = 1'b0;
        ov_d   = 1'b0;
        unique case (op)
            OP_ADD, OP_INC: begin
                c_d    = sum9[7:0];
                cout_d = sum9[8];
                ov_d   = (A[7] == arith_b[7]) && (sum9[7] != A[7]);
            end
            OP_SUB, OP_DEC: begin
                c_d    = sum9[7:0];
                cout_d = sum9[8];
                ov_d   = (A[7] != arith_b[7]) && (sum9[7] != A[7]);
            end
            OP_AND: c_d = A & B;
            OP_OR:  c_d = A | B;
            OP_XOR: c_d = A ^ B;
            OP_NOT: c_d = ~A;
            default: c_d = 8'h00;
        endcase
        // Flags come from the new result, not from the registered one.
        neg_d  = c_d[7];
        zero_d = (c_d == 8'h00);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_q    <= 8'h00;
            cout_q <= 1'b0;
            ov_q   <= 1'b0;
            neg_q  <= 1'b0;
            zero_q <= 1'b0;   // deliberately 0 in reset even though C is 0
        end else begin
            c_q    <= c_d;
            cout_q <= cout_d;
            ov_q   <= ov_d;
            neg_q  <= neg_d;
            zero_q <= zero_d;
        end
    end

    assign C    = c_q;
    assign cout = cout_q;
    assign Ov   = ov_q;
    assign Neg  = neg_q;
    assign Zero = zero_q;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: reset behaviour, directed vectors, reset mid-stream, model sweep.
// Latency: checks each result one clock after its operands are driven.
// Backpressure: none; one vector is driven per cycle.
module tb_alu;

    logic       clk;
    logic       rst_n;
    logic [7:0] A, B;
    logic       X, Y, Z;
    logic [7:0] C;
    logic       cout, Ov, Neg, Zero;

    alu dut (
        .clk  (clk),
        .rst_n(rst_n),
        .A    (A),
        .B    (B),
        .X    (X),
        .Y    (Y),
        .Z    (Z),
        .C    (C),
        .cout (cout),
        .Ov   (Ov),
        .Neg  (Neg),
        .Zero (Zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packed result layout: {C[7:0], cout, Ov, Neg, Zero}
    typedef struct {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] c;
        logic       co;
        logic       ov;
        logic       ng;
        logic       zr;
    } vec_t;

    vec_t       vecs[$];
    logic [11:0] sbq[$];
    int          n_tests = 0;
    int          n_fail  = 0;

    function automatic vec_t mk(logic [2:0] op, logic [7:0] a, logic [7:0] b,
                                logic [7:0] c, logic co, logic ov, logic ng, logic zr);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.c = c;
        v.co = co; v.ov = ov; v.ng = ng; v.zr = zr;
        return v;
    endfunction

    // Reference model written in integer arithmetic: carry/borrow from unsigned
    // range checks, overflow from the signed result leaving -128..127.
    function automatic logic [11:0] model(logic [2:0] op, logic [7:0] a, logic [7:0] b);
        int ua, ub, sa, sb, r, sr;
        logic [7:0] c;
        logic co, ov;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        co = 1'b0;
        ov = 1'b0;
        r  = 0;
        if (op == 3'd2 || op == 3'd3) begin
            ub = 1;
            sb = 1;
        end
        case (op)
            3'd0, 3'd2: begin
                r  = ua + ub;
                sr = sa + sb;
                co = (r > 255);
                ov = (sr > 127) || (sr < -128);
                c  = r[7:0];
            end
            3'd1, 3'd3: begin
                r  = ua - ub;
                sr = sa - sb;
                co = (ua < ub);
                ov = (sr > 127) || (sr < -128);
                c  = r[7:0];
            end
            3'd4:    c = a & b;
            3'd5:    c = a | b;
            3'd6:    c = a ^ b;
            default: c = ~a;
        endcase
        return {c, co, ov, c[7], (c == 8'h00)};
    endfunction

    function automatic logic [11:0] got();
        return {C, cout, Ov, Neg, Zero};
    endfunction

    task automatic compare(input string name, input logic [11:0] act, input logic [11:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got C=%02h cout=%b Ov=%b Neg=%b Zero=%b, want C=%02h cout=%b Ov=%b Neg=%b Zero=%b",
                     name, act[11:4], act[3], act[2], act[1], act[0],
                     exp[11:4], exp[3], exp[2], exp[1], exp[0]);
        end
    endtask

    // Pop the oldest expected result and compare it with the current outputs.
    task automatic check_out(input string name);
        logic [11:0] exp;
        if (sbq.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: scoreboard empty, got C=%02h", name, C);
        end else begin
            exp = sbq.pop_front();
            compare(name, got(), exp);
        end
    endtask

    // Drive one operation, record its expected result, check it one edge later.
    task automatic drive(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic [11:0] exp, input string name);
        {X, Y, Z} = op;
        A = a;
        B = b;
        sbq.push_back(exp);
        @(posedge clk);
        #1;
        check_out(name);
    endtask

    logic [7:0] b_list[12];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got tests=%0d want completion", n_tests);
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Directed vectors: {op, A, B, C, cout, Ov, Neg, Zero}
        vecs.push_back(mk(3'b000, 8'd15,  8'd20,  8'd35,  0, 0, 0, 0));
        vecs.push_back(mk(3'b001, 8'd20,  8'd15,  8'd5,   0, 0, 0, 0));
        vecs.push_back(mk(3'b001, 8'd25,  8'd50,  8'hE7,  1, 0, 1, 0));
        vecs.push_back(mk(3'b001, 8'd125, 8'd100, 8'd25,  0, 0, 0, 0));
        vecs.push_back(mk(3'b000, 8'h9C,  8'hCE,  8'h6A,  1, 1, 0, 0));
        vecs.push_back(mk(3'b010, 8'h7F,  8'h33,  8'h80,  0, 1, 1, 0));
        vecs.push_back(mk(3'b011, 8'h00,  8'hC4,  8'hFF,  1, 0, 1, 0));
        vecs.push_back(mk(3'b100, 8'd3,   8'd2,   8'd2,   0, 0, 0, 0));
        vecs.push_back(mk(3'b101, 8'd3,   8'd12,  8'd15,  0, 0, 0, 0));
        vecs.push_back(mk(3'b110, 8'd1,   8'd2,   8'd3,   0, 0, 0, 0));
        vecs.push_back(mk(3'b111, 8'd1,   8'h5A,  8'hFE,  0, 0, 1, 0));
        vecs.push_back(mk(3'b000, 8'hFF,  8'h01,  8'h00,  1, 0, 0, 1));
        vecs.push_back(mk(3'b000, 8'h7F,  8'h01,  8'h80,  0, 1, 1, 0));
        vecs.push_back(mk(3'b001, 8'h00,  8'h01,  8'hFF,  1, 0, 1, 0));
        vecs.push_back(mk(3'b001, 8'h80,  8'h01,  8'h7F,  0, 1, 0, 0));
        vecs.push_back(mk(3'b110, 8'h55,  8'h55,  8'h00,  0, 0, 0, 1));
        vecs.push_back(mk(3'b010, 8'hFF,  8'h00,  8'h00,  1, 0, 0, 1));
        vecs.push_back(mk(3'b011, 8'h80,  8'hFF,  8'h7F,  0, 1, 0, 0));
        vecs.push_back(mk(3'b100, 8'hF0,  8'h0F,  8'h00,  0, 0, 0, 1));
        vecs.push_back(mk(3'b001, 8'h7F,  8'hFF,  8'h80,  1, 1, 1, 0));

        b_list = '{8'h00, 8'h01, 8'h02, 8'h0F, 8'h3C, 8'h7E,
                   8'h7F, 8'h80, 8'h81, 8'hA5, 8'hFE, 8'hFF};

        // Reset state, checked before any clock edge.
        rst_n = 1'b0;
        A = 8'h00; B = 8'h00; {X, Y, Z} = 3'b000;
        #2;
        compare("reset_initial", got(), 12'h000);
        repeat (2) @(posedge clk);
        #1;
        compare("reset_held", got(), 12'h000);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table.
        foreach (vecs[i]) begin
            drive(vecs[i].op, vecs[i].a, vecs[i].b,
                  {vecs[i].c, vecs[i].co, vecs[i].ov, vecs[i].ng, vecs[i].zr},
                  $sformatf("vec%0d", i));
        end

        // Reset mid-stream: a nonzero result is on the outputs, another op is in flight.
        drive(3'b000, 8'h7F, 8'h01, {8'h80, 4'b0110}, "pre_reset");
        {X, Y, Z} = 3'b110; A = 8'hF0; B = 8'h0F;
        #2;
        rst_n = 1'b0;
        #1;
        compare("async_reset", got(), 12'h000);
        sbq.delete();
        @(posedge clk);
        #1;
        compare("reset_discards_inflight", got(), 12'h000);
        #2;
        rst_n = 1'b1;
        // First edge after release captures the waiting XOR normally.
        sbq.push_back({8'hFF, 4'b0010});
        @(posedge clk);
        #1;
        check_out("first_after_reset");

        // Back-to-back op changes every cycle.
        drive(3'b111, 8'h00, 8'h00, {8'hFF, 4'b0010}, "b2b_not");
        drive(3'b010, 8'hFF, 8'h00, {8'h00, 4'b1001}, "b2b_inc");
        drive(3'b101, 8'h80, 8'h01, {8'h81, 4'b0010}, "b2b_or");

        // Sweep every op over all A, a spread of B (fixed B for unary ops).
        for (int op = 0; op < 8; op++) begin
            for (int a = 0; a < 256; a++) begin
                if (op == 2 || op == 3 || op == 7) begin
                    drive(3'(op), 8'(a), 8'hA5, model(3'(op), 8'(a), 8'hA5),
                          $sformatf("sweep op%0d a%02h", op, a));
                end else begin
                    for (int bi = 0; bi < 12; bi++) begin
                        drive(3'(op), 8'(a), b_list[bi], model(3'(op), 8'(a), b_list[bi]),
                              $sformatf("sweep op%0d a%02h b%02h", op, a, b_list[bi]));
                    end
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
